// File: rtl/multicycle_sequencer_pkg.sv
// multicycle_sequencer_pkg: opcodes, states, ALU-op and trap-cause encodings shared by the sequencer
package multicycle_sequencer_pkg;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b11;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  function automatic logic legal_op(input logic [6:0] op);
    return op inside {OP_LD, OP_SD, OP_R, OP_I, OP_BEQ};
  endfunction
endpackage

// File: rtl/multicycle_sequencer_bus_watchdog.sv
// multicycle_sequencer_bus_watchdog: flags a request left unacknowledged for ACK_TIMEOUT cycles
module multicycle_sequencer_bus_watchdog #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic timeout
);
  localparam int W = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    cnt <= (!rst_n || !req || ack) ? '0 : cnt + W'(1);
  end
  assign timeout = ACK_TIMEOUT != 0 && req && !ack && cnt == W'(ACK_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control path for an RV64I subset
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_zero,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic [1:0]      alu_op,
  output logic            alu_src,
  output logic            mem2reg,
  output logic            reg_write,
  output logic            retire,
  output logic            trap,
  output logic [1:0]      trap_cause
);
  state_t state, state_nx;
  logic [XLEN-1:0] pc_nx, pc4, target;
  logic [31:0] instr_nx;
  logic [1:0] cause_nx;
  logic [6:0] op;
  logic aligned, timeout;
  assign op = instr[6:0];
  assign pc4 = pc + XLEN'(4);
  assign target = alu_zero ? pc + (imm << 1) : pc4;
  assign aligned = target[1:0] == 2'b00;
  assign imem_req = rst_n && state == FETCH;
  assign imem_addr = pc;
  assign dmem_req = rst_n && state == MEM;
  assign dmem_we = dmem_req && op == OP_SD;
  assign trap = state == TRAP;
  multicycle_sequencer_bus_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wdog (
    .clk,
    .rst_n,
    .req(imem_req || dmem_req),
    .ack(imem_req ? imem_ack : dmem_ack),
    .timeout
  );
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    instr_nx = instr;
    cause_nx = trap_cause;
    alu_op = ALU_ADD;
    alu_src = 1'b0;
    mem2reg = 1'b0;
    reg_write = 1'b0;
    retire = 1'b0;
    if (state inside {EXEC, MEM, WB}) begin
      alu_op = op == OP_BEQ ? ALU_SUB : (op == OP_R || op == OP_I) ? ALU_FUNCT : ALU_ADD;
      alu_src = op inside {OP_LD, OP_SD, OP_I};
    end
    case (state)
      FETCH: begin
        if (imem_ack) begin
          instr_nx = imem_rdata;
          state_nx = DECODE;
        end else if (timeout) begin
          state_nx = TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        state_nx = legal_op(op) ? EXEC : TRAP;
        cause_nx = legal_op(op) ? CAUSE_NONE : CAUSE_ILLEGAL;
      end
      EXEC: begin
        if (op == OP_BEQ) begin
          state_nx = aligned ? FETCH : TRAP;
          cause_nx = aligned ? CAUSE_NONE : CAUSE_MISALIGN;
          pc_nx = aligned ? target : pc;
          retire = aligned;
        end else begin
          state_nx = (op == OP_LD || op == OP_SD) ? MEM : WB;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          state_nx = op == OP_SD ? FETCH : WB;
          pc_nx = op == OP_SD ? pc4 : pc;
          retire = op == OP_SD;
        end else if (timeout) begin
          state_nx = TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      WB: begin
        reg_write = 1'b1;
        mem2reg = op == OP_LD;
        pc_nx = pc4;
        retire = 1'b1;
        state_nx = FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      instr <= NOP;
      trap_cause <= CAUSE_NONE;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      instr <= instr_nx;
      trap_cause <= cause_nx;
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction-level check of multicycle_sequencer
module tb_multicycle_sequencer;
  localparam int T = 4;
  localparam logic [63:0] RPC = 64'h100;
  localparam logic [6:0] LD = 7'b0000011, SD = 7'b0100011, RR = 7'b0110011, RI = 7'b0010011, BQ = 7'b1100011;
  logic clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] imm = '0;
  logic imem_req, dmem_req, dmem_we, alu_src, mem2reg, reg_write, retire, trap;
  logic [63:0] imem_addr, pc;
  logic [31:0] instr;
  logic [1:0] alu_op, trap_cause;
  int n_chk = 0, n_pass = 0;
  logic [63:0] mpc;
  always #5 clk = ~clk;
  multicycle_sequencer #(.XLEN(64), .RESET_PC(RPC), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .imm(imm),
    .alu_zero(alu_zero), .pc(pc), .instr(instr), .alu_op(alu_op), .alu_src(alu_src), .mem2reg(mem2reg),
    .reg_write(reg_write), .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic quiet_and_reset();
    int b;
    b = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire || reg_write || !trap) b++;
    end
    check("trap_absorb", 64'(b), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_pc", pc, RPC);
    check("rst_trap", 64'({trap, trap_cause}), 64'd0);
    check("rst_fetch", 64'(imem_req), 64'd1);
    mpc = RPC;
  endtask
  task automatic run(input logic [31:0] w, input logic [63:0] iv, input logic z, input int iw, input int dw);
    logic [6:0] o;
    bit legal, is_mem, has_wb, fetched, done;
    logic [63:0] tgt, e_pc;
    logic [1:0] e_cause, e_aop, aop;
    logic e_src, asrc;
    int e_ireq, e_dreq, lat, cyc, ni, nd, nrw, nm, nret, bad, rw_cyc;
    o = w[6:0];
    legal = o inside {LD, SD, RR, RI, BQ};
    is_mem = o inside {LD, SD};
    has_wb = o inside {LD, RR, RI};
    fetched = iw < T;
    tgt = (o == BQ && z) ? mpc + iv * 2 : mpc + 64'd4;
    e_cause = !fetched ? 2'd2 : !legal ? 2'd1 : (o == BQ && tgt[1:0] != 2'b00) ? 2'd3 : (is_mem && dw >= T) ? 2'd2 : 2'd0;
    e_ireq = fetched ? iw + 1 : T;
    e_dreq = (fetched && legal && is_mem) ? (dw < T ? dw + 1 : T) : 0;
    lat = iw + 3 + (is_mem ? dw + 1 : 0) + (has_wb ? 1 : 0);
    e_pc = e_cause == 2'd0 ? tgt : mpc;
    e_aop = o == BQ ? 2'b01 : (o inside {RR, RI}) ? 2'b10 : 2'b00;
    e_src = o inside {LD, SD, RI};
    imem_rdata = w;
    imm = iv;
    alu_zero = z;
    #1;
    cyc = 0; ni = 0; nd = 0; nrw = 0; nm = 0; nret = 0; bad = 0; rw_cyc = 0; done = 0; aop = '0; asrc = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      if (imem_req) begin
        ni++;
        if (imem_addr != mpc) bad++;
        imem_ack = ni == iw + 1;
      end
      if (dmem_req) begin
        nd++;
        if (dmem_we != (o == SD)) bad++;
        dmem_ack = nd == dw + 1;
      end
      #1;
      if (reg_write) begin
        nrw++;
        rw_cyc = cyc;
        aop = alu_op;
        asrc = alu_src;
        if (mem2reg) nm++;
      end
      if (retire) nret++;
      if (retire || trap) done = 1;
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
    end
    check("done", 64'(done), 64'd1);
    check("trap", 64'(trap), 64'(e_cause != 2'd0));
    check("cause", 64'(trap_cause), 64'(e_cause));
    check("pc", pc, e_pc);
    check("ireq_cycles", 64'(ni), 64'(e_ireq));
    check("dreq_cycles", 64'(nd), 64'(e_dreq));
    check("addr_we", 64'(bad), 64'd0);
    check("reg_write", 64'(nrw), 64'(e_cause == 2'd0 && has_wb));
    check("mem2reg", 64'(nm), 64'(e_cause == 2'd0 && o == LD));
    check("retire", 64'(nret), 64'(e_cause == 2'd0));
    if (fetched) check("instr", 64'(instr), 64'(w));
    if (e_cause == 2'd0) begin
      check("latency", 64'(cyc), 64'(lat));
      if (has_wb) begin
        check("wb_cycle", 64'(rw_cyc), 64'(lat));
        check("alu_op", 64'(aop), 64'(e_aop));
        check("alu_src", 64'(asrc), 64'(e_src));
      end
    end
    mpc = e_pc;
    if (e_cause != 2'd0) quiet_and_reset();
  endtask
  task automatic reset_in_mem();
    int k;
    k = 0;
    imem_rdata = {25'h0, LD};
    #1;
    while (!dmem_req && k < 20) begin
      imem_ack = imem_req;
      #1;
      @(negedge clk);
      imem_ack = 1'b0;
      k++;
    end
    check("mem_reached", 64'(dmem_req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    #1;
    check("rst_mem_dreq", 64'(dmem_req), 64'd0);
    check("rst_mem_quiet", 64'({reg_write, retire}), 64'd0);
    check("rst_mem_addr", imem_addr, RPC);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("rst_mem_ignored", 64'({imem_req, dmem_req, reg_write, retire, trap}), 64'b10000);
    check("rst_mem_pc", pc, RPC);
    mpc = RPC;
  endtask
  initial begin
    int iw, dw;
    logic [6:0] o;
    logic [63:0] iv;
    logic [31:0] w;
    repeat (2) @(negedge clk);
    check("reset_pc", pc, RPC);
    check("reset_instr", 64'(instr), 64'h13);
    check("reset_outs", 64'({imem_req, dmem_req, reg_write, retire, trap, trap_cause}), 64'd0);
    rst_n = 1'b1;
    mpc = RPC;
    run(32'h003100b3, 64'd0, 1'b0, 0, 0);
    run(32'h00013083, 64'd8, 1'b0, 0, 3);
    run(32'h00000063, 64'($signed(64'h200 - mpc) >>> 1), 1'b1, 0, 0);
    run(32'h00000063, 64'd8, 1'b1, 0, 0);
    run(32'h00000063, -64'd8, 1'b1, 0, 0);
    run(32'h00000063, 64'd8, 1'b0, 1, 0);
    run(32'h00000063, -64'd2, 1'b1, 0, 0);
    run(32'h00000063, 64'd1, 1'b1, 0, 0);
    run(32'h00113023, 64'd0, 1'b0, 2, 1);
    run(32'h0000007f, 64'd0, 1'b0, 0, 0);
    run(32'h003100b3, 64'd0, 1'b0, T, 0);
    run(32'h003100b3, 64'd0, 1'b0, T - 1, 0);
    run(32'h00013083, 64'd0, 1'b0, 0, T);
    run(32'h00113023, 64'd0, 1'b0, 0, T - 1);
    run(32'h00000063, 64'($signed(64'hFFFF_FFFF_FFFF_FFFC - mpc) >>> 1), 1'b1, 0, 0);
    run(32'h00108093, 64'd0, 1'b0, 0, 0);
    run(32'h003100b3, 64'd0, 1'b0, 0, 0);
    reset_in_mem();
    run(32'h003100b3, 64'd0, 1'b0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 15))
        0, 1, 2:    o = LD;
        3, 4, 5:    o = SD;
        6, 7, 8:    o = RR;
        9, 10, 11:  o = RI;
        12, 13, 14: o = BQ;
        default: begin
          o = 7'($urandom);
          while (o inside {LD, SD, RR, RI, BQ}) o = 7'($urandom);
        end
      endcase
      iv = o == BQ ? 64'($urandom_range(0, 31)) - 64'd16 : {$urandom, $urandom};
      iw = $urandom_range(0, 9) == 0 ? T + $urandom_range(0, 1) : $urandom_range(0, 2);
      dw = $urandom_range(0, 9) == 0 ? T + $urandom_range(0, 1) : $urandom_range(0, 3);
      w = $urandom;
      w[6:0] = o;
      run(w, iv, 1'($urandom), iw, dw);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
